// File: rtl/fb_plot_sink.sv
// Pixel-plot sink: captures in-screen plots into a 160x120x3 framebuffer, with clear sweep,
// statistics counters and registered readback. Optional overwrite counting via FB_OVERWRITE_CNT_EN.
module fb_plot_sink #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       vga_x,
    input  logic [6:0]       vga_y,
    input  logic [2:0]       vga_colour,
    input  logic             vga_plot,
    input  logic             clr_start,
    output logic             clr_done,
    input  logic [7:0]       rd_x,
    input  logic [6:0]       rd_y,
    output logic [2:0]       rd_colour,
    output logic [CNT_W-1:0] plot_count,
    output logic [CNT_W-1:0] clip_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] overwrite_count
);

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned NPIX   = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;

    logic [2:0] mem [0:NPIX-1];

    logic              plot_in_screen, rd_in_screen, clr_accept, plot_ok;
    logic [ADDR_W-1:0] plot_addr, rd_addr, wr_addr;
    logic              wr_en;
    logic [2:0]        wr_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Address decode for plot and readback ports
    assign plot_in_screen = (32'(vga_x) < SCREEN_W) && (32'(vga_y) < SCREEN_H);
    assign rd_in_screen   = (32'(rd_x) < SCREEN_W) && (32'(rd_y) < SCREEN_H);
    assign plot_addr      = ADDR_W'(vga_y) * ADDR_W'(SCREEN_W) + ADDR_W'(vga_x);
    assign rd_addr        = ADDR_W'(rd_y) * ADDR_W'(SCREEN_W) + ADDR_W'(rd_x);

    assign clr_accept = (state == IDLE) && clr_start;
    assign plot_ok    = vga_plot && plot_in_screen && (state != CLEAR);
    assign wr_en      = (state == CLEAR) || plot_ok;
    assign wr_addr    = (state == CLEAR) ? addr : plot_addr;
    assign wr_data    = (state == CLEAR) ? 3'd0 : vga_colour;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    addr_nxt  = '0;
                end
            end
            CLEAR: begin
                addr_nxt = addr + ADDR_W'(1);
                if (addr == ADDR_W'(NPIX - 1)) begin
                    state_nxt = DONE;
                    addr_nxt  = '0;
                end
            end
            DONE: begin
                if (!clr_start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // clr_done lags DONE entry by one edge and drops on the same edge that leaves DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_done <= 1'b0;
        else        clr_done <= (state == DONE) && clr_start;
    end

    // Framebuffer: single write port, read-before-write registered readback
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rd_colour <= 3'd0;
        else if (rd_in_screen) rd_colour <= mem[rd_addr];
        else                   rd_colour <= 3'd0;
    end

`ifdef FB_OVERWRITE_CNT_EN
    logic flags [0:NPIX-1];
    logic [CNT_W-1:0] ovw_q;

    always_ff @(posedge clk) begin
        if (wr_en) flags[wr_addr] <= (state != CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ovw_q <= '0;
        else if (clr_accept)                 ovw_q <= '0;
        else if (plot_ok && flags[plot_addr]) ovw_q <= sat_inc(ovw_q);
    end

    assign overwrite_count = ovw_q;
`else
    assign overwrite_count = '0;
`endif

    // Statistics counters, zeroed on clear acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plot_count <= '0;
            clip_count <= '0;
            drop_count <= '0;
        end else if (clr_accept) begin
            plot_count <= '0;
            clip_count <= '0;
            drop_count <= '0;
        end else if (vga_plot) begin
            if (state == CLEAR)      drop_count <= sat_inc(drop_count);
            else if (plot_in_screen) plot_count <= sat_inc(plot_count);
            else                     clip_count <= sat_inc(clip_count);
        end
    end

endmodule

// File: tb/tb_fb_plot_sink.sv
// Directed self-checking bench for fb_plot_sink (clear timing, plots, clipping, drops, reset, overwrite).
module tb_fb_plot_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clr_start;
    logic        clr_done;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_colour;
    logic [15:0] plot_count, clip_count, drop_count, overwrite_count;

    int checks = 0;
    int failures = 0;

    fb_plot_sink dut (
        .clk(clk), .rst_n(rst_n),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .clr_start(clr_start), .clr_done(clr_done),
        .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
        .plot_count(plot_count), .clip_count(clip_count), .drop_count(drop_count),
        .overwrite_count(overwrite_count)
    );

    always #5 clk = ~clk;

    // Raise clr_start and return the number of edges after acceptance until clr_done reads high
    task automatic run_clear(output int k);
        clr_start = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (clr_done) break;
            k++;
            if (k > 25000) begin k = -1; break; end
        end
    endtask

    task automatic do_plot(input int x, input int y, input int c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
        @(negedge clk);
        vga_plot = 1'b0;
    endtask

    task automatic do_read(input int x, input int y);
        rd_x = 8'(x); rd_y = 7'(y);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clr_start = 1'b0; rd_x = '0; rd_y = '0;
        #1;
        checks++;
        if (clr_done !== 1'b0 || rd_colour !== 3'd0) begin
            failures++; $display("FAIL reset_outputs clr_done=%b rd_colour=%0d want 0/0", clr_done, rd_colour);
        end
        checks++;
        if (plot_count !== 0 || clip_count !== 0 || drop_count !== 0 || overwrite_count !== 0) begin
            failures++; $display("FAIL reset_counters got %0d %0d %0d %0d want 0", plot_count, clip_count, drop_count, overwrite_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clear;
        int k;
        run_clear(k);
        checks++;
        if (k !== 19201) begin
            failures++; $display("FAIL clear_latency got %0d want 19201", k);
        end
        clr_start = 1'b0;
        @(negedge clk);
        checks++;
        if (clr_done !== 1'b0) begin
            failures++; $display("FAIL clr_done_drop got %b want 0", clr_done);
        end
        do_read(0, 0);
        checks++;
        if (rd_colour !== 3'd0) begin failures++; $display("FAIL rd_0_0 got %0d want 0", rd_colour); end
        do_read(159, 119);
        checks++;
        if (rd_colour !== 3'd0) begin failures++; $display("FAIL rd_159_119 got %0d want 0", rd_colour); end
        do_read(80, 60);
        checks++;
        if (rd_colour !== 3'd0) begin failures++; $display("FAIL rd_80_60 got %0d want 0", rd_colour); end
    endtask

    task automatic test_plot;
        do_plot(10, 20, 5);
        do_plot(159, 119, 7);
        do_read(10, 20);
        checks++;
        if (rd_colour !== 3'd5) begin failures++; $display("FAIL rd_10_20 got %0d want 5", rd_colour); end
        do_read(159, 119);
        checks++;
        if (rd_colour !== 3'd7) begin failures++; $display("FAIL rd_159_119_plot got %0d want 7", rd_colour); end
        checks++;
        if (plot_count !== 16'd2 || clip_count !== 16'd0) begin
            failures++; $display("FAIL plot_counts plot=%0d clip=%0d want 2/0", plot_count, clip_count);
        end
    endtask

    task automatic test_clip;
        do_plot(160, 0, 6);
        do_plot(0, 120, 6);
        do_plot(255, 127, 6);
        checks++;
        if (clip_count !== 16'd3 || plot_count !== 16'd2) begin
            failures++; $display("FAIL clip_counts clip=%0d plot=%0d want 3/2", clip_count, plot_count);
        end
        do_read(160, 0);
        checks++;
        if (rd_colour !== 3'd0) begin failures++; $display("FAIL rd_160_0 got %0d want 0", rd_colour); end
        do_read(0, 1);
        checks++;
        if (rd_colour !== 3'd0) begin failures++; $display("FAIL rd_0_1_alias got %0d want 0", rd_colour); end
        do_read(10, 20);
        checks++;
        if (rd_colour !== 3'd5) begin failures++; $display("FAIL rd_10_20_kept got %0d want 5", rd_colour); end
    endtask

    task automatic test_drop;
        int k = 0;
        int bad = 0;
        clr_start = 1'b1;
        vga_x = 8'd30; vga_y = 7'd30; vga_colour = 3'd4;
        forever begin
            @(negedge clk);
            if (clr_done) break;
            if (k == 100) vga_plot = 1'b1;
            if (k == 110) vga_plot = 1'b0;
            k++;
            if (k > 25000) break;
        end
        checks++;
        if (k !== 19201) begin failures++; $display("FAIL drop_clear_latency got %0d want 19201", k); end
        checks++;
        if (drop_count !== 16'd10 || plot_count !== 16'd0 || clip_count !== 16'd0) begin
            failures++; $display("FAIL drop_counts drop=%0d plot=%0d clip=%0d want 10/0/0", drop_count, plot_count, clip_count);
        end
        clr_start = 1'b0;
        @(negedge clk);
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                do_read(x, y);
                if (rd_colour !== 3'd0) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL full_clear nonzero_pixels=%0d want 0", bad); end
    endtask

    task automatic test_reset_mid_clear;
        int k = 0;
        clr_start = 1'b1;
        forever begin
            @(negedge clk);
            if (k == 10) vga_plot = 1'b1;
            if (k == 11) vga_plot = 1'b0;
            if (k == 5000) break;
            k++;
        end
        checks++;
        if (drop_count !== 16'd1) begin failures++; $display("FAIL pre_reset_drop got %0d want 1", drop_count); end
        rst_n = 1'b0;
        clr_start = 1'b0;
        #1;
        checks++;
        if (clr_done !== 1'b0 || drop_count !== 0 || plot_count !== 0 || clip_count !== 0) begin
            failures++; $display("FAIL mid_reset done=%b drop=%0d plot=%0d clip=%0d want 0", clr_done, drop_count, plot_count, clip_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_clear(k);
        checks++;
        if (k !== 19201) begin failures++; $display("FAIL reclear_latency got %0d want 19201", k); end
        clr_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overwrite;
        int exp_ovw;
`ifdef FB_OVERWRITE_CNT_EN
        exp_ovw = 2;
`else
        exp_ovw = 0;
`endif
        do_plot(40, 40, 1);
        do_plot(40, 40, 2);
        do_plot(40, 40, 3);
        checks++;
        if (overwrite_count !== 16'(exp_ovw)) begin
            failures++; $display("FAIL overwrite_count got %0d want %0d", overwrite_count, exp_ovw);
        end
        checks++;
        if (plot_count !== 16'd3) begin failures++; $display("FAIL overwrite_plots got %0d want 3", plot_count); end
        do_read(40, 40);
        checks++;
        if (rd_colour !== 3'd3) begin failures++; $display("FAIL rd_40_40 got %0d want 3", rd_colour); end
    endtask

    initial begin
        test_reset;
        test_clear;
        test_plot;
        test_clip;
        test_drop;
        test_reset_mid_clear;
        test_overwrite;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
